// File: rtl/bsg_dmc_pkg.sv
// Shared definitions for the bsg_dmc user-interface layer.
// app_cmd_e mirrors the Xilinx MIG app_cmd encoding.
package bsg_dmc_pkg;

    typedef enum logic [2:0] {
        e_app_wr = 3'b000,
        e_app_rd = 3'b001
    } app_cmd_e;

endpackage

// File: rtl/bsg_dmc_ui_burst_master.sv
// Turns whole-burst requests into app_* UI traffic for bsg_dmc and packs
// returned read words into one burst-wide response; one request in flight.
module bsg_dmc_ui_burst_master
    import bsg_dmc_pkg::*;
#(
    parameter int ui_addr_width_p     = 28,
    parameter int ui_data_width_p     = 32,
    parameter int ui_burst_length_p   = 8,
    parameter int burst_data_width_lp = ui_data_width_p * ui_burst_length_p,
    parameter int ui_mask_width_lp    = ui_data_width_p >> 3
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          init_calib_complete_i,

    input  logic                                          v_i,
    output logic                                          ready_o,
    input  logic [2:0]                                    cmd_i,
    input  logic [ui_addr_width_p-1:0]                    addr_i,
    input  logic [burst_data_width_lp-1:0]                data_i,
    input  logic [ui_mask_width_lp*ui_burst_length_p-1:0] mask_i,

    output logic                                          data_v_o,
    output logic [burst_data_width_lp-1:0]                data_o,
    input  logic                                          yumi_i,

    output logic [ui_addr_width_p-1:0]                    app_addr_o,
    output logic [2:0]                                    app_cmd_o,
    output logic                                          app_en_o,
    input  logic                                          app_rdy_i,
    output logic                                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                    app_wdf_data_o,
    output logic [ui_mask_width_lp-1:0]                   app_wdf_mask_o,
    output logic                                          app_wdf_end_o,
    input  logic                                          app_wdf_rdy_i,
    input  logic                                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                    app_rd_data_i,
    input  logic                                          app_rd_data_end_i,

    output logic                                          error_o
);

    localparam int cnt_width_lp        = $clog2(ui_burst_length_p);
    localparam int burst_mask_width_lp = ui_mask_width_lp * ui_burst_length_p;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(ui_burst_length_p - 1);

    typedef enum logic [2:0] {
        e_idle,
        e_cmd,
        e_wdata,
        e_rwait,
        e_rdone
    } state_e;

    state_e                           state_q, state_d;
    logic [cnt_width_lp-1:0]          cnt_q, cnt_d;
    logic [2:0]                       cmd_q, cmd_d;
    logic [ui_addr_width_p-1:0]       addr_q, addr_d;
    logic [burst_data_width_lp-1:0]   burst_q, burst_d;
    logic [burst_mask_width_lp-1:0]   mask_q, mask_d;
    logic                             ready_q, ready_d;
    logic                             error_q, error_d;
    logic                             last_word;

    assign last_word = (cnt_q == last_cnt_lp);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        mask_d  = mask_q;
        error_d = error_q;

        unique case (state_q)
            e_idle: begin
                if (v_i && ready_q) begin
                    cmd_d   = cmd_i;
                    addr_d  = addr_i;
                    burst_d = data_i;
                    mask_d  = mask_i;
                    cnt_d   = '0;
                    if (cmd_i == e_app_wr || cmd_i == e_app_rd) begin
                        state_d = e_cmd;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            e_cmd: begin
                if (app_rdy_i) begin
                    state_d = (cmd_q == e_app_wr) ? e_wdata : e_rwait;
                end
            end
            e_wdata: begin
                if (app_wdf_rdy_i) begin
                    cnt_d = cnt_q + cnt_width_lp'(1);
                    if (last_word) state_d = e_idle;
                end
            end
            e_rwait: begin
                // The write burst register is reused as the read assembly buffer.
                if (app_rd_data_valid_i) begin
                    burst_d[cnt_q*ui_data_width_p +: ui_data_width_p] = app_rd_data_i;
                    cnt_d = cnt_q + cnt_width_lp'(1);
                    if (app_rd_data_end_i != last_word) error_d = 1'b1;
                    if (last_word) state_d = e_rdone;
                end
            end
            e_rdone: begin
                if (yumi_i) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase

        // Read data arriving outside RWAIT is dropped and flagged.
        if (app_rd_data_valid_i && state_q != e_rwait) error_d = 1'b1;

        ready_d = (state_d == e_idle) && init_calib_complete_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign ready_o        = ready_q;
    assign error_o        = error_q;
    assign app_en_o       = (state_q == e_cmd);
    assign app_addr_o     = addr_q;
    assign app_cmd_o      = cmd_q;
    assign app_wdf_wren_o = (state_q == e_wdata);
    assign app_wdf_end_o  = (state_q == e_wdata) && last_word;
    assign app_wdf_data_o = burst_q[cnt_q*ui_data_width_p +: ui_data_width_p];
    assign app_wdf_mask_o = mask_q[cnt_q*ui_mask_width_lp +: ui_mask_width_lp];
    assign data_v_o       = (state_q == e_rdone);
    assign data_o         = burst_q;

endmodule

// File: tb/tb_bsg_dmc_ui_burst_master.sv
// Self-checking bench for bsg_dmc_ui_burst_master: transaction table with a
// beat/burst scoreboard plus hand-written reset and error sequences.
module tb_bsg_dmc_ui_burst_master;
    import bsg_dmc_pkg::*;

    localparam int AW = 28;
    localparam int W  = 32;
    localparam int B  = 8;
    localparam int BW = W * B;
    localparam int MW = W / 8;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           init_calib_complete_i;
    logic           v_i;
    logic           ready_o;
    logic [2:0]     cmd_i;
    logic [AW-1:0]  addr_i;
    logic [BW-1:0]  data_i;
    logic [MW*B-1:0] mask_i;
    logic           data_v_o;
    logic [BW-1:0]  data_o;
    logic           yumi_i;
    logic [AW-1:0]  app_addr_o;
    logic [2:0]     app_cmd_o;
    logic           app_en_o;
    logic           app_rdy_i;
    logic           app_wdf_wren_o;
    logic [W-1:0]   app_wdf_data_o;
    logic [MW-1:0]  app_wdf_mask_o;
    logic           app_wdf_end_o;
    logic           app_wdf_rdy_i;
    logic           app_rd_data_valid_i;
    logic [W-1:0]   app_rd_data_i;
    logic           app_rd_data_end_i;
    logic           error_o;

    bsg_dmc_ui_burst_master #(
        .ui_addr_width_p  (AW),
        .ui_data_width_p  (W),
        .ui_burst_length_p(B)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .init_calib_complete_i(init_calib_complete_i),
        .v_i                  (v_i),
        .ready_o              (ready_o),
        .cmd_i                (cmd_i),
        .addr_i               (addr_i),
        .data_i               (data_i),
        .mask_i               (mask_i),
        .data_v_o             (data_v_o),
        .data_o               (data_o),
        .yumi_i               (yumi_i),
        .app_addr_o           (app_addr_o),
        .app_cmd_o            (app_cmd_o),
        .app_en_o             (app_en_o),
        .app_rdy_i            (app_rdy_i),
        .app_wdf_wren_o       (app_wdf_wren_o),
        .app_wdf_data_o       (app_wdf_data_o),
        .app_wdf_mask_o       (app_wdf_mask_o),
        .app_wdf_end_o        (app_wdf_end_o),
        .app_wdf_rdy_i        (app_wdf_rdy_i),
        .app_rd_data_valid_i  (app_rd_data_valid_i),
        .app_rd_data_i        (app_rd_data_i),
        .app_rd_data_end_i    (app_rd_data_end_i),
        .error_o              (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      cmd;
        logic [AW-1:0]   addr;
        logic [BW-1:0]   data;
        logic [MW*B-1:0] mask;
        int              cmd_stall;
        int              wdf_pat;     // 0 always ready, 1 toggling, 2 random
        int              rd_gap;
        int              yumi_delay;
        int              bad_end;     // word index that also raises end, -1 none
        int              exp_lat;     // accept-to-ready cycles for writes, -1 skip
        logic            exp_err;
    } txn_t;

    typedef struct {
        logic [W-1:0]  d;
        logic [MW-1:0] m;
        logic          e;
    } beat_t;

    beat_t         wq[$];
    logic [BW-1:0] rq[$];
    logic [BW-1:0] mem[logic [AW-1:0]];
    txn_t          tbl[7];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_burst(input logic [W-1:0] base);
        logic [BW-1:0] r;
        for (int k = 0; k < B; k++) r[k*W +: W] = base + W'(k);
        return r;
    endfunction

    function automatic logic [BW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return mk_burst(32'hDEAD_0000);
    endfunction

    task automatic mem_wr(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [MW*B-1:0] m);
        logic [BW-1:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < MW*B; b++) if (!m[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        mem[a] = cur;
    endtask

    function automatic txn_t mk_txn(input logic [2:0] c, input logic [AW-1:0] a,
                                    input logic [BW-1:0] d, input logic [MW*B-1:0] m,
                                    input int stall, input int pat, input int gap,
                                    input int ydel, input int bad, input int lat, input logic err);
        txn_t t;
        t.cmd = c; t.addr = a; t.data = d; t.mask = m; t.cmd_stall = stall;
        t.wdf_pat = pat; t.rd_gap = gap; t.yumi_delay = ydel; t.bad_end = bad;
        t.exp_lat = lat; t.exp_err = err;
        return t;
    endfunction

    task automatic wait_ready();
        int cyc = 0;
        while (!ready_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_ready", ready_o, 1);
    endtask

    task automatic run_txn(input txn_t t);
        logic          is_rd;
        logic [BW-1:0] exp_b;
        logic [BW-1:0] snap;
        beat_t         bt;
        int            cyc, stall_left, gap_left, k_rd;
        bit            cmd_acc, fin, hold_bad;
        is_rd = (t.cmd == e_app_rd);
        wait_ready();
        v_i = 1'b1; cmd_i = t.cmd; addr_i = t.addr; data_i = t.data; mask_i = t.mask;
        exp_b = mem_rd(t.addr);
        if (is_rd) begin
            rq.push_back(exp_b);
        end else begin
            for (int k = 0; k < B; k++) begin
                bt.d = t.data[k*W +: W];
                bt.m = t.mask[k*MW +: MW];
                bt.e = (k == B-1);
                wq.push_back(bt);
            end
            mem_wr(t.addr, t.data, t.mask);
        end
        @(posedge clk); #1;
        v_i = 1'b0; addr_i = ~t.addr; data_i = ~t.data; mask_i = ~t.mask;
        @(negedge clk);
        chk("accept_to_en", app_en_o, 1);
        chk("cmd_addr", app_addr_o, t.addr);
        chk("cmd_cmd", app_cmd_o, t.cmd);
        cyc = 1; stall_left = t.cmd_stall; gap_left = 0; k_rd = 0;
        cmd_acc = 0; fin = 0; hold_bad = 0;
        while (!fin && cyc < 500) begin
            app_rdy_i = (stall_left == 0);
            if (app_en_o && (ready_o || app_wdf_wren_o)) hold_bad = 1;
            if (app_en_o && (app_addr_o != t.addr || app_cmd_o != t.cmd)) hold_bad = 1;
            if (!is_rd) begin
                case (t.wdf_pat)
                    0:       app_wdf_rdy_i = 1'b1;
                    1:       app_wdf_rdy_i = (cyc % 2) == 1;
                    default: app_wdf_rdy_i = 1'($urandom_range(0, 1));
                endcase
                if (app_wdf_wren_o && app_wdf_rdy_i) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                        fin = 1;
                    end else begin
                        bt = wq.pop_front();
                        chk("wdf_data", app_wdf_data_o, bt.d);
                        chk("wdf_mask", app_wdf_mask_o, bt.m);
                        chk("wdf_end", app_wdf_end_o, bt.e);
                        if (wq.size() == 0) fin = 1;
                    end
                end
            end else if (cmd_acc && k_rd < B) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    app_rd_data_valid_i = 1'b1;
                    app_rd_data_i = exp_b[k_rd*W +: W];
                    app_rd_data_end_i = (k_rd == B-1) || (k_rd == t.bad_end);
                    k_rd++;
                    gap_left = t.rd_gap;
                end
            end
            if (app_en_o && app_rdy_i) cmd_acc = 1;
            if (app_en_o && stall_left > 0) stall_left--;
            @(posedge clk); #1;
            app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
            app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
            @(negedge clk);
            cyc++;
            if (is_rd && k_rd == B) fin = 1;
        end
        chk("txn_timeout", fin, 1);
        chk("cmd_hold", hold_bad, 0);
        if (!is_rd) begin
            chk("ready_after_write", ready_o, 1);
            chk("wren_after_write", app_wdf_wren_o, 0);
            if (t.exp_lat >= 0) chk("write_latency", cyc, t.exp_lat);
        end else begin
            chk("data_v_after_last", data_v_o, 1);
            if (rq.size() == 0) chk("rq_empty", 1, 0);
            else chk("read_burst", data_o, rq.pop_front());
            snap = data_o;
            hold_bad = 0;
            for (int i = 0; i < t.yumi_delay; i++) begin
                @(negedge clk);
                if (!data_v_o || data_o !== snap) hold_bad = 1;
            end
            chk("rdone_hold", hold_bad, 0);
            yumi_i = 1'b1;
            @(posedge clk); #1;
            yumi_i = 1'b0;
            @(negedge clk);
            chk("ready_after_yumi", ready_o, 1);
            chk("data_v_after_yumi", data_v_o, 0);
        end
        chk("error_state", error_o, t.exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; init_calib_complete_i = 1'b0; v_i = 1'b0; cmd_i = '0;
        addr_i = '0; data_i = '0; mask_i = '0; yumi_i = 1'b0; app_rdy_i = 1'b0;
        app_wdf_rdy_i = 1'b0; app_rd_data_valid_i = 1'b0; app_rd_data_i = '0;
        app_rd_data_end_i = 1'b0;

        tbl[0] = mk_txn(e_app_wr, 28'h100, mk_burst(32'hA0), '0, 0, 0, 0, 0, -1, 10, 1'b0);
        tbl[1] = mk_txn(e_app_wr, 28'h140, mk_burst(32'h50), 32'h0000_F00F, 0, 1, 0, 0, -1, -1, 1'b0);
        tbl[2] = mk_txn(e_app_rd, 28'h100, '0, '0, 0, 0, 2, 5, -1, -1, 1'b0);
        tbl[3] = mk_txn(e_app_rd, 28'h140, '0, '0, 10, 0, 0, 0, -1, -1, 1'b0);
        tbl[4] = mk_txn(e_app_wr, 28'h200, {8{$urandom()}} ^ mk_burst($urandom()), '0, 3, 2, 0, 0, -1, -1, 1'b0);
        tbl[5] = mk_txn(e_app_rd, 28'h200, '0, '0, 0, 0, 1, 2, -1, -1, 1'b0);
        tbl[6] = mk_txn(e_app_rd, 28'h300, '0, '0, 1, 0, 0, 1, -1, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_app_en", app_en_o, 0);
        chk("rst_wren", app_wdf_wren_o, 0);
        chk("rst_wdf_end", app_wdf_end_o, 0);
        chk("rst_data_v", data_v_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_app_addr", app_addr_o, 0);
        chk("rst_app_cmd", app_cmd_o, 0);
        chk("rst_wdf_data", app_wdf_data_o, 0);
        chk("rst_wdf_mask", app_wdf_mask_o, 0);
        chk("rst_data_o", data_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready_no_calib", ready_o, 0);
        init_calib_complete_i = 1'b1;
        @(negedge clk);
        chk("ready_after_calib", ready_o, 1);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Illegal command: no CMD phase, sticky error.
        wait_ready();
        v_i = 1'b1; cmd_i = 3'b111; addr_i = 28'h400;
        @(posedge clk); #1;
        v_i = 1'b0;
        @(negedge clk);
        chk("illegal_no_en", app_en_o, 0);
        chk("illegal_error", error_o, 1);
        chk("illegal_back_idle", ready_o, 1);

        // Reset in WDATA after 3 accepted words.
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("error_cleared", error_o, 0);
        wait_ready();
        v_i = 1'b1; cmd_i = e_app_wr; addr_i = 28'h180; data_i = mk_burst(32'hC0); mask_i = '0;
        app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_word3", app_wdf_data_o, 32'hC3);
        reset_i = 1'b1;
        #1;
        chk("midrst_wren", app_wdf_wren_o, 0);
        chk("midrst_en", app_en_o, 0);
        chk("midrst_ready", ready_o, 0);
        chk("midrst_wdata", app_wdf_data_o, 0);
        chk("midrst_addr", app_addr_o, 0);
        app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        run_txn(mk_txn(e_app_wr, 28'h180, mk_burst(32'hD0), '0, 0, 0, 0, 0, -1, 10, 1'b0));

        // Stray read data in IDLE, then a read with an early end flag.
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 32'h1234_5678;
        @(posedge clk); #1;
        app_rd_data_valid_i = 1'b0;
        @(negedge clk);
        chk("stray_valid_error", error_o, 1);
        repeat (3) @(negedge clk);
        chk("error_sticky", error_o, 1);
        run_txn(mk_txn(e_app_rd, 28'h100, '0, '0, 0, 0, 0, 1, 3, -1, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bsg_dmc_ui_burst_master.md
# bsg_dmc_ui_burst_master

- Converts whole-burst memory requests into the Xilinx-style `app_*` user interface of `bsg_dmc`, and packs returned read words back into one burst-wide response.
- Sits directly upstream of `bsg_dmc`, between a request source (trace replayer or tile-side adapter) and the DMC UI port.
- Serialises one request at a time and supports one outstanding read.
- Flags protocol violations from the DMC side in a sticky error bit.

## Interface
Parameters:
- `ui_addr_width_p`, 28: UI address width.
- `ui_data_width_p`, 32: UI data word width.
- `ui_burst_length_p`, 8: words per burst; must be ≥2 and a power of two.
- `burst_data_width_lp`, derived: `ui_data_width_p*ui_burst_length_p`.
- `ui_mask_width_lp`, derived: `ui_data_width_p>>3`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk_i`  in  1  clock; same domain as DMC `ui_clk_i`.
  - `reset_i`  in  1  asynchronous, active-high reset.
- Status input:
  - `init_calib_complete_i`  in  1  DMC calibration done.
- Request side:
  - `v_i`  in  1  request valid.
  - `ready_o`  out  1  request accept.
  - `cmd_i`  in  3  `app_cmd_e`; only WR and RD are legal.
  - `addr_i`  in  `ui_addr_width_p`  burst address.
  - `data_i`  in  `burst_data_width_lp`  write burst; word k is `data_i[k*W +: W]`.
  - `mask_i`  in  `ui_mask_width_lp*ui_burst_length_p`  byte mask; 1 = byte not written.
- Response side:
  - `data_v_o`  out  1  read burst valid.
  - `data_o`  out  `burst_data_width_lp`  read burst; word 0 in the LSBs.
  - `yumi_i`  in  1  consumer takes the read burst.
- DMC UI side:
  - `app_addr_o`, `app_cmd_o`, `app_en_o`  out  command channel.
  - `app_rdy_i`  in  command ready.
  - `app_wdf_wren_o`, `app_wdf_data_o`, `app_wdf_mask_o`, `app_wdf_end_o`  out  write-data channel.
  - `app_wdf_rdy_i`  in  write-data ready.
  - `app_rd_data_valid_i`, `app_rd_data_i`, `app_rd_data_end_i`  in  read-data channel; no backpressure.
- `error_o`  out  1  sticky protocol error.

## Operation
States and transitions:
- IDLE:
  - `ready_o = init_calib_complete_i`.
  - On `v_i & ready_o`, latch cmd/addr/data/mask, clear the word counter, go to CMD.
- CMD:
  - Drive `app_en_o=1` with the latched addr/cmd.
  - On `app_rdy_i`: WR goes to WDATA, RD goes to RWAIT.
- WDATA:
  - `app_wdf_wren_o=1`; data and mask are word `cnt` of the latched burst.
  - `app_wdf_end_o = (cnt == ui_burst_length_p-1)`.
  - Each `app_wdf_rdy_i` increments `cnt`; the last accepted word returns to IDLE.
- RWAIT:
  - Each `app_rd_data_valid_i` writes `app_rd_data_i` into word `cnt` and increments it.
  - The valid word with `cnt == ui_burst_length_p-1` moves to RDONE.
- RDONE:
  - `data_v_o=1`, with `data_o` held stable.
  - `yumi_i` returns to IDLE.

Counter:
- `cnt` is `$clog2(ui_burst_length_p)` bits and wraps to 0 after the last word.

Error conditions (each sets `error_o`, which stays set until reset):
- `app_rd_data_valid_i` asserted in any state other than RWAIT; the data is dropped.
- `app_rd_data_end_i` differs from `(cnt == ui_burst_length_p-1)` on a valid read word.
- Latched cmd is neither WR nor RD. In this case CMD is skipped and the FSM returns to IDLE.

Other rules:
- If `init_calib_complete_i` drops while busy, the in-flight request completes and no new request is accepted.
- `yumi_i` outside RDONE is ignored.

## Timing
- Reset values:
  - State = IDLE, `cnt`=0.
  - `ready_o`, `app_en_o`, `app_wdf_wren_o`, `app_wdf_end_o`, `data_v_o`, `error_o` = 0.
  - `app_addr_o`, `app_cmd_o`, `app_wdf_data_o`, `app_wdf_mask_o`, `data_o` = 0.
- Reset mid-operation: the partial burst is abandoned with no further `app_*` activity.
- All outputs are registered or decoded from state; there is no combinational path from `v_i` to `app_*`.
- Accept to `app_en_o` rising: 1 cycle.
- With `app_rdy_i` and `app_wdf_rdy_i` held high, a write takes 1 (accept) + 1 (CMD) + B data cycles.
  - The next `ready_o` is asserted in the cycle after the last write word.
- Read: `data_v_o` rises the cycle after the last read word; `ready_o` rises the cycle after `yumi_i`.
- `app_en_o` and `app_wdf_wren_o` are never high in the same cycle.
- A deasserted ready holds all payload stable.

## Structure
- `app_cmd_e` and its encodings come from `bsg_dmc_pkg`; no new package types are needed.
- The state enum is local to the module.
- No sub-module: the counter, burst registers and FSM are inline.
- Word selection uses an indexed part-select on the latched burst.

## Test plan
- Reset held, `init_calib_complete_i`=0 -> `ready_o`=0 and all `app_*` outputs 0.
  - Raise calib -> `ready_o`=1 next cycle.
- Write, addr 0x100, data words 0..7 = 0xA0..0xA7, mask 0:
  - 8 wren beats in order; `app_wdf_end_o` only on 0xA7.
  - Toggling `app_wdf_rdy_i` 50% holds the word until accepted.
- Read, addr 0x100, model returns 8 words 2 cycles apart, end on the 8th:
  - `data_v_o`=1 with `data_o` = {0xA7..0xA0}.
  - Holding `yumi_i`=0 for 5 cycles keeps `data_o` stable.
- `app_rdy_i` held 0 for 10 cycles in CMD -> `app_en_o` stays 1 with addr/cmd stable; `ready_o` stays 0.
- `app_rd_data_valid_i` pulsed in IDLE -> `error_o`=1 and stays 1.
  - A subsequent read with `app_rd_data_end_i` on word 3 -> `error_o` remains 1.
- Reset asserted in WDATA after 3 words -> immediate return to reset values; the next write starts at word 0.
